// File: rtl/word_adder_seq.sv
// word_adder_seq
//
// Word-serial multi-precision adder controller. A single N-bit ripple
// adder slice is reused once per word, LSW first. The carry between words
// is kept in a register from one beat to the next. Operand word pairs
// arrive on a ready/valid stream. Sum words leave through a one-entry
// output register on a ready/valid stream. The final word is flagged with
// out_last and carries the carry-out on cout.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   start      begin an operation (sampled only while idle)
//   len        word count for the operation, 0 behaves as 1
//   cin        carry into word 0, sampled together with start
//   in_valid   operand word pair valid
//   in_ready   operand word accepted this cycle
//   a, b       operand words
//   out_valid  result word valid
//   out_ready  sink accepts the result word
//   s          result sum word
//   out_last   result word is the most significant word
//   cout       carry out of the MSW, 0 unless out_valid & out_last
//   busy       operation in progress
module word_adder_seq #(
    parameter int unsigned N     = 8,
    parameter int unsigned LEN_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     s,
    output logic             out_last,
    output logic             cout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             carry_q, carry_d;
    logic [N-1:0]     s_q, s_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             cout_q, cout_d;

    logic [N-1:0]     sum_w;
    logic             carry_out_w;
    logic             accept;
    logic             is_last;

    // Ripple slice: bit i uses the carry out of bit i-1, bit 0 uses carry_q.
    always_comb begin : ripple
        logic c;
        sum_w = '0;
        c     = carry_q;
        for (int unsigned i = 0; i < N; i++) begin
            sum_w[i] = a[i] ^ b[i] ^ c;
            c        = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        carry_out_w = c;
    end

    // The output register is free when it is empty or is being drained
    // this cycle. No path from in_valid.
    assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_last  = (rem_q == REM_ONE);

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        carry_d     = carry_q;
        s_d         = s_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        cout_d      = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = (len == '0) ? REM_ONE : len;
                    carry_d = cin;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (accept) begin
                    // A drain on the same edge is absorbed by the reload.
                    s_d         = sum_w;
                    carry_d     = carry_out_w;
                    out_valid_d = 1'b1;
                    out_last_d  = is_last;
                    cout_d      = is_last ? carry_out_w : 1'b0;
                    rem_d       = rem_q - REM_ONE;
                    if (is_last) begin
                        state_d = FLUSH;
                    end
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end

            FLUSH: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    cout_d      = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            carry_q     <= 1'b0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            carry_q     <= carry_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            cout_q      <= cout_d;
        end
    end

    assign s         = s_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign cout      = cout_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_word_adder_seq.sv
// tb_word_adder_seq
//
// Bench for word_adder_seq (N=8, LEN_W=3). Table of multi-word operations
// with their expected sum words and final carry, plus hand-written
// sequences for backpressure and mid-operation reset. Expected result
// beats are queued when an operand word is accepted and compared when the
// sink takes the result.
module tb_word_adder_seq;

    localparam int N     = 8;
    localparam int LEN_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             cin = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     a = '0;
    logic [N-1:0]     b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [N-1:0]     s;
    logic             out_last;
    logic             cout;
    logic             busy;

    word_adder_seq #(.N(N), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .out_last  (out_last),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] s;
        logic         last;
        logic         cout;
    } exp_t;

    typedef struct {
        int unsigned     len;
        logic            cin;
        logic [6:0][7:0] a;
        logic [6:0][7:0] b;
        logic [6:0][7:0] s;
        logic            cout;
        logic            pulse;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mke(input logic [N-1:0] sv, input logic l, input logic c);
        exp_t e;
        e.s    = sv;
        e.last = l;
        e.cout = c;
        return e;
    endfunction

    function automatic vec_t mk(input int unsigned l, input logic c,
                                input logic [55:0] av, input logic [55:0] bv,
                                input logic [55:0] sv, input logic co, input logic p);
        vec_t v;
        v.len   = l;
        v.cin   = c;
        v.a     = av;
        v.b     = bv;
        v.s     = sv;
        v.cout  = co;
        v.pulse = p;
        return v;
    endfunction

    // Result checker: the handshake completes on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got s=0x%0h with no expected beat", s);
            end else begin
                e = sb.pop_front();
                chk("s", s, e.s);
                chk("out_last", out_last, e.last);
                chk("cout", cout, e.cout);
            end
        end
    end

    // Called at #1 after a rising edge with in_valid/a/b already driven.
    task automatic wait_accept(input exp_t e, output int waits);
        waits = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                break;
            end
            waits++;
            if (waits > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no in_ready expected in_ready within 50 cycles");
                break;
            end
            @(posedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int edges);
        edges = 0;
        forever begin
            @(posedge clk);
            #1;
            edges++;
            if (!busy) break;
            if (edges > 50) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout: got busy=1 expected busy=0 within 50 cycles");
                break;
            end
        end
    endtask

    task automatic do_op(input vec_t v);
        int nw;
        int w;
        int n;
        int edges;
        nw = (v.len == 0) ? 1 : int'(v.len);
        start = 1'b1;
        len   = LEN_W'(v.len);
        cin   = v.cin;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        edges = 1;
        for (int i = 0; i < nw; i++) begin
            in_valid = 1'b1;
            a = v.a[i];
            b = v.b[i];
            if (v.pulse && i == 1) begin
                start = 1'b1;
                len   = LEN_W'(1);
                cin   = 1'b1;
            end
            wait_accept(mke(v.s[i], i == nw - 1, (i == nw - 1) ? v.cout : 1'b0), w);
            start = 1'b0;
            edges += w + 1;
        end
        in_valid = 1'b0;
        wait_idle(n);
        edges += n;
        chk("op_edges", edges, nw + 2);
    endtask

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        int w;
        int n;

        tbl[0] = mk(1, 1'b0, 56'h0F,             56'h01,       56'h10,       1'b0, 1'b0);
        tbl[1] = mk(2, 1'b0, 56'h00FF,           56'h0001,     56'h0100,     1'b0, 1'b0);
        tbl[2] = mk(3, 1'b1, 56'hFFFFFF,         56'hFFFFFF,   56'hFFFFFF,   1'b1, 1'b0);
        tbl[3] = mk(0, 1'b0, 56'h80,             56'h80,       56'h00,       1'b1, 1'b0);
        tbl[4] = mk(4, 1'b0, 56'h04030201,       56'h40302010, 56'h44332211, 1'b0, 1'b0);
        tbl[5] = mk(4, 1'b0, 56'hFF007F80,       56'h01000080, 56'h00008000, 1'b1, 1'b0);
        tbl[6] = mk(5, 1'b0, 56'hFFFFFFFFFF,     56'h01,       56'h00,       1'b1, 1'b1);
        tbl[7] = mk(7, 1'b1, 56'hFFFFFFFFFFFFFF, 56'h00,       56'h00,       1'b1, 1'b0);

        // Reset state
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_cout", cout, 0);
        chk("rst_s", s, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", in_ready, 0);

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i]);
        end

        // Backpressure: sink stalls for 3 cycles after the first result.
        start = 1'b1;
        len   = LEN_W'(2);
        cin   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_valid = 1'b1;
        a = 8'h05;
        b = 8'h01;
        wait_accept(mke(8'h06, 1'b0, 1'b0), w);
        out_ready = 1'b0;
        a = 8'h06;
        b = 8'h02;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_s_stable", s, 8'h06);
            chk("bp_last_stable", out_last, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_accept(mke(8'h08, 1'b1, 1'b0), w);
        chk("bp_accept_wait", w, 0);
        in_valid = 1'b0;
        wait_idle(n);
        chk("bp_idle_edges", n, 1);

        // Reset after the first beat of a 3-word operation.
        out_ready = 1'b0;
        start = 1'b1;
        len   = LEN_W'(3);
        cin   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_valid = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        wait_accept(mke(8'h00, 1'b0, 1'b0), w);
        in_valid = 1'b0;
        chk("mid_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_cout", cout, 0);
        chk("mid_rst_s", s, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        do_op(mk(1, 1'b0, 56'h01, 56'h01, 56'h02, 1'b0, 1'b0));

        @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
